// File: rtl/bomb_scheduler.sv
// ---------------------------------------------------------------------------
// bomb_scheduler
//   Shared pool of NUM_SLOTS bomb slots for a two-player game. Each rising
//   edge of a player's drop key requests a bomb at the player's current
//   32-px tile. The request is granted into the lowest free slot when the
//   player is under quota and the tile is not already occupied. An armed
//   bomb counts down FUSE_SEC OneSecPulse ticks, blasts for one cycle, and
//   then frees its slot.
//
//   Optional feature: define BOMB_CHAIN_EN so that a blasting slot detonates
//   armed slots in the same tile row or column within BLAST_RANGE tiles. The
//   chain advances one hop per cycle.
//
// Ports
//   clk                      system clock (the only clock)
//   resetN                   synchronous, active-low reset
//   OneSecPulse              one-cycle tick, once per second
//   drop_key[1:0]            level drop key, bit p = player p
//   p0/p1_topLeftX/Y[10:0]   player positions in pixels
//   slot_x/slot_y            packed signed 11-bit top-left per slot;
//                            640/480 while the slot is free
//   slot_active              slot is ARMED or BLAST
//   slot_owner               owning player per slot
//   blast                    one-cycle explosion pulse per slot
//   grant/deny[1:0]          one-cycle drop-request result per player
// ---------------------------------------------------------------------------
module bomb_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int FUSE_SEC       = 3,
    parameter int MAX_PER_PLAYER = 2,
    parameter int BLAST_RANGE    = 2
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          OneSecPulse,
    input  logic [1:0]                    drop_key,
    input  logic [10:0]                   p0_topLeftX,
    input  logic [10:0]                   p0_topLeftY,
    input  logic [10:0]                   p1_topLeftX,
    input  logic [10:0]                   p1_topLeftY,
    output logic signed [11*NUM_SLOTS-1:0] slot_x,
    output logic signed [11*NUM_SLOTS-1:0] slot_y,
    output logic [NUM_SLOTS-1:0]          slot_active,
    output logic [NUM_SLOTS-1:0]          slot_owner,
    output logic [NUM_SLOTS-1:0]          blast,
    output logic [1:0]                    grant,
    output logic [1:0]                    deny
);

    localparam logic [1:0] S_FREE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_BLAST = 2'd2;

    localparam int CNT_W = $clog2(MAX_PER_PLAYER + 1);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [2:0]         FUSE_INIT = 3'(FUSE_SEC);
    localparam logic signed [10:0] FREE_X    = 11'sd640;
    localparam logic signed [10:0] FREE_Y    = 11'sd480;

    if (FUSE_SEC < 1 || FUSE_SEC > 7) begin : g_fuse_range
        $error("bomb_scheduler: FUSE_SEC must be within 1..7");
    end
    if (BLAST_RANGE < 0) begin : g_blast_range
        $error("bomb_scheduler: BLAST_RANGE must not be negative");
    end

    function automatic logic signed [10:0] snap(input logic [10:0] pos);
        return signed'({pos[10:5], 5'b0});
    endfunction

`ifdef BOMB_CHAIN_EN
    // Same row or column, and within BLAST_RANGE tiles along the other axis.
    function automatic logic in_reach(input logic signed [10:0] ax, input logic signed [10:0] ay,
                                      input logic signed [10:0] bx, input logic signed [10:0] by);
        int dx;
        int dy;
        dx = int'(ax) - int'(bx);
        dy = int'(ay) - int'(by);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return ((ay == by) && (dx <= BLAST_RANGE * 32)) ||
               ((ax == bx) && (dy <= BLAST_RANGE * 32));
    endfunction
`endif

    // Registered slot state
    logic [1:0]         state [NUM_SLOTS];
    logic signed [10:0] sx    [NUM_SLOTS];
    logic signed [10:0] sy    [NUM_SLOTS];
    logic [2:0]         timer [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] own;
    logic [CNT_W-1:0]   held  [2];
    logic [1:0]         key_q;
    logic               ptr;

    // Request evaluation
    logic [1:0]         req;
    logic signed [10:0] tx [2];
    logic signed [10:0] ty [2];
    logic [1:0]         tile_busy;
    logic               win, lose;
    logic               w_found, l_found, w_ok, l_ok;
    logic [IDX_W-1:0]   w_slot, l_slot;
    logic [1:0]         grant_d, deny_d;
    logic [NUM_SLOTS-1:0] chain_hit;
    logic [CNT_W-1:0]   held_d [2];

    // Only tile-snapped positions matter; the sub-tile bits are ignored.
    logic unused_pos_lsbs;
    assign unused_pos_lsbs = ^{p0_topLeftX[4:0], p0_topLeftY[4:0],
                               p1_topLeftX[4:0], p1_topLeftY[4:0]};

    assign req = drop_key & ~key_q;

    always_comb begin
        tx[0] = snap(p0_topLeftX);
        ty[0] = snap(p0_topLeftY);
        tx[1] = snap(p1_topLeftX);
        ty[1] = snap(p1_topLeftY);

        tile_busy = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (state[i] != S_FREE && sx[i] == tx[p] && sy[i] == ty[p])
                    tile_busy[p] = 1'b1;
            end
        end

        // A lone requester wins outright; on contention the pointer decides.
        win  = (req == 2'b11) ? ptr : req[1];
        lose = ~win;

        w_found = 1'b0;
        w_slot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (state[i] == S_FREE) begin
                w_found = 1'b1;
                w_slot  = IDX_W'(i);
            end
        end
        w_ok = req[win] && w_found && (held[win] < CNT_W'(MAX_PER_PLAYER)) && !tile_busy[win];

        // The loser sees the pool as it stands after the winner's allocation.
        l_found = 1'b0;
        l_slot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (state[i] == S_FREE && !(w_ok && w_slot == IDX_W'(i))) begin
                l_found = 1'b1;
                l_slot  = IDX_W'(i);
            end
        end
        l_ok = (req == 2'b11) && l_found && (held[lose] < CNT_W'(MAX_PER_PLAYER)) &&
               !tile_busy[lose] && !(tx[lose] == tx[win] && ty[lose] == ty[win]);

        grant_d = '0;
        deny_d  = '0;
        if (req[win]) begin
            grant_d[win] = w_ok;
            deny_d[win]  = !w_ok;
        end
        if (req == 2'b11) begin
            grant_d[lose] = l_ok;
            deny_d[lose]  = !l_ok;
        end

        chain_hit = '0;
`ifdef BOMB_CHAIN_EN
        for (int j = 0; j < NUM_SLOTS; j++) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (i != j && state[i] == S_BLAST && state[j] == S_ARMED &&
                    in_reach(sx[i], sy[i], sx[j], sy[j]))
                    chain_hit[j] = 1'b1;
            end
        end
`endif
    end

    // Held count: +1 per grant, -1 per owned slot leaving BLAST this cycle.
    always_comb begin
        int cnt;
        for (int p = 0; p < 2; p++) begin
            cnt = int'(held[p]);
            if (grant_d[p]) cnt = cnt + 1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (state[i] == S_BLAST && own[i] == 1'(p)) cnt = cnt - 1;
            end
            held_d[p] = CNT_W'(cnt);
        end
    end

    // ---- state register boundary ----
    always_ff @(posedge clk) begin
        if (!resetN) begin
            key_q <= 2'b11;
            ptr   <= 1'b0;
            grant <= '0;
            deny  <= '0;
            own   <= '0;
            for (int p = 0; p < 2; p++) held[p] <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state[i] <= S_FREE;
                sx[i]    <= FREE_X;
                sy[i]    <= FREE_Y;
                timer[i] <= FUSE_INIT;
            end
        end else begin
            key_q   <= drop_key;
            grant   <= grant_d;
            deny    <= deny_d;
            held[0] <= held_d[0];
            held[1] <= held_d[1];
            if (req == 2'b11) ptr <= lose;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                case (state[i])
                    S_FREE: begin
                        if (w_ok && w_slot == IDX_W'(i)) begin
                            state[i] <= S_ARMED;
                            sx[i]    <= tx[win];
                            sy[i]    <= ty[win];
                            own[i]   <= win;
                            timer[i] <= FUSE_INIT;
                        end else if (l_ok && l_slot == IDX_W'(i)) begin
                            state[i] <= S_ARMED;
                            sx[i]    <= tx[lose];
                            sy[i]    <= ty[lose];
                            own[i]   <= lose;
                            timer[i] <= FUSE_INIT;
                        end
                    end
                    S_ARMED: begin
                        if (chain_hit[i] || (OneSecPulse && timer[i] == 3'd1))
                            state[i] <= S_BLAST;
                        else if (OneSecPulse)
                            timer[i] <= timer[i] - 3'd1;
                    end
                    default: begin
                        state[i] <= S_FREE;
                        sx[i]    <= FREE_X;
                        sy[i]    <= FREE_Y;
                    end
                endcase
            end
        end
    end

    always_comb begin
        slot_x      = '0;
        slot_y      = '0;
        slot_active = '0;
        blast       = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_x[i*11 +: 11] = sx[i];
            slot_y[i*11 +: 11] = sy[i];
            slot_active[i]     = (state[i] != S_FREE);
            blast[i]           = (state[i] == S_BLAST);
        end
    end

    assign slot_owner = own;

endmodule

// File: tb/tb_bomb_scheduler.sv
module tb_bomb_scheduler;
    localparam int NS    = 4;
    localparam int FUSE  = 3;
    localparam int MAXP  = 2;
    localparam int RANGE = 2;
`ifdef BOMB_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN;
    logic        OneSecPulse;
    logic [1:0]  drop_key;
    logic [10:0] p0x, p0y, p1x, p1y;
    logic signed [11*NS-1:0] slot_x, slot_y;
    logic [NS-1:0] slot_active, slot_owner, blast;
    logic [1:0]  grant, deny;

    bomb_scheduler #(
        .NUM_SLOTS(NS), .FUSE_SEC(FUSE), .MAX_PER_PLAYER(MAXP), .BLAST_RANGE(RANGE)
    ) dut (
        .clk(clk), .resetN(resetN), .OneSecPulse(OneSecPulse), .drop_key(drop_key),
        .p0_topLeftX(p0x), .p0_topLeftY(p0y), .p1_topLeftX(p1x), .p1_topLeftY(p1y),
        .slot_x(slot_x), .slot_y(slot_y), .slot_active(slot_active),
        .slot_owner(slot_owner), .blast(blast), .grant(grant), .deny(deny)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a slot is an occupied/boom record with seconds left.
    typedef struct {
        bit used;
        bit boom;
        int left;
        int x;
        int y;
        int owner;
    } slot_t;

    slot_t    m_slot [NS];
    int       m_ptr;
    bit [1:0] m_keyq;
    bit [1:0] m_grant, m_deny;

    function automatic bit tile_taken(int x, int y);
        for (int i = 0; i < NS; i++)
            if (m_slot[i].used && m_slot[i].x == x && m_slot[i].y == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit near(int ax, int ay, int bx, int by);
        int dx, dy;
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        return (ay == by && dx <= RANGE * 32) || (ax == bx && dy <= RANGE * 32);
    endfunction

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_clock();
        slot_t nx [NS];
        int held [2];
        int tx [2];
        int ty [2];
        int order [2];
        bit [1:0] req;
        int n, first, taken, p, slot;
        bit ok;
        if (!resetN) begin
            for (int i = 0; i < NS; i++) begin
                m_slot[i].used = 1'b0; m_slot[i].boom = 1'b0; m_slot[i].left = FUSE;
                m_slot[i].x = 640; m_slot[i].y = 480; m_slot[i].owner = 0;
            end
            m_ptr = 0; m_keyq = 2'b11; m_grant = 2'b00; m_deny = 2'b00;
            return;
        end
        req = drop_key & ~m_keyq;
        tx[0] = (int'(p0x) / 32) * 32; ty[0] = (int'(p0y) / 32) * 32;
        tx[1] = (int'(p1x) / 32) * 32; ty[1] = (int'(p1y) / 32) * 32;
        for (int q = 0; q < 2; q++) begin
            held[q] = 0;
            for (int i = 0; i < NS; i++)
                if (m_slot[i].used && m_slot[i].owner == q) held[q]++;
        end
        nx = m_slot;
        for (int i = 0; i < NS; i++) begin
            if (m_slot[i].boom) begin
                nx[i].used = 1'b0; nx[i].boom = 1'b0; nx[i].x = 640; nx[i].y = 480;
            end else if (m_slot[i].used && OneSecPulse) begin
                nx[i].left = m_slot[i].left - 1;
                if (nx[i].left == 0) nx[i].boom = 1'b1;
            end
        end
        if (CHAIN) begin
            for (int j = 0; j < NS; j++)
                if (m_slot[j].used && !m_slot[j].boom)
                    for (int i = 0; i < NS; i++)
                        if (i != j && m_slot[i].boom &&
                            near(m_slot[i].x, m_slot[i].y, m_slot[j].x, m_slot[j].y))
                            nx[j].boom = 1'b1;
        end
        m_grant = 2'b00; m_deny = 2'b00;
        n = 0; first = 0; order[0] = 0; order[1] = 0;
        if (req == 2'b11) begin
            first = m_ptr; order[0] = m_ptr; order[1] = 1 - m_ptr; n = 2;
        end else if (req != 2'b00) begin
            first = req[1] ? 1 : 0; order[0] = first; n = 1;
        end
        taken = -1;
        for (int k = 0; k < n; k++) begin
            p = order[k];
            slot = -1;
            for (int i = NS - 1; i >= 0; i--)
                if (!m_slot[i].used && i != taken) slot = i;
            ok = (slot >= 0) && (held[p] < MAXP) && !tile_taken(tx[p], ty[p]) &&
                 !(k == 1 && tx[p] == tx[first] && ty[p] == ty[first]);
            if (ok) begin
                nx[slot].used = 1'b1; nx[slot].boom = 1'b0; nx[slot].left = FUSE;
                nx[slot].x = tx[p]; nx[slot].y = ty[p]; nx[slot].owner = p;
                taken = slot;
                m_grant[p] = 1'b1;
            end else begin
                m_deny[p] = 1'b1;
            end
        end
        if (n == 2) m_ptr = 1 - m_ptr;
        m_keyq = drop_key;
        m_slot = nx;
    endtask

    task automatic check_all(input string tag);
        logic [11*NS-1:0] ex, ey;
        logic [NS-1:0] ea, eb, eo;
        for (int i = 0; i < NS; i++) begin
            ex[i*11 +: 11] = 11'(m_slot[i].x);
            ey[i*11 +: 11] = 11'(m_slot[i].y);
            ea[i] = m_slot[i].used;
            eb[i] = m_slot[i].boom;
            eo[i] = m_slot[i].owner[0];
        end
        vectors++;
        assert (slot_active === ea) else begin
            miscompares++; $error("FAIL %s slot_active got %b want %b", tag, slot_active, ea);
        end
        vectors++;
        assert (blast === eb) else begin
            miscompares++; $error("FAIL %s blast got %b want %b", tag, blast, eb);
        end
        vectors++;
        assert (slot_owner === eo) else begin
            miscompares++; $error("FAIL %s slot_owner got %b want %b", tag, slot_owner, eo);
        end
        vectors++;
        assert (slot_x === ex) else begin
            miscompares++; $error("FAIL %s slot_x got %h want %h", tag, slot_x, ex);
        end
        vectors++;
        assert (slot_y === ey) else begin
            miscompares++; $error("FAIL %s slot_y got %h want %h", tag, slot_y, ey);
        end
        vectors++;
        assert (grant === m_grant) else begin
            miscompares++; $error("FAIL %s grant got %b want %b", tag, grant, m_grant);
        end
        vectors++;
        assert (deny === m_deny) else begin
            miscompares++; $error("FAIL %s deny got %b want %b", tag, deny, m_deny);
        end
    endtask

    task automatic expect_val(input string tag, input int got, input int want);
        vectors++;
        assert (got === want) else begin
            miscompares++; $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic cyc(input logic [1:0] keys, input logic pulse, input string tag);
        drop_key    = keys;
        OneSecPulse = pulse;
        model_clock();
        @(posedge clk);
        #1;
        check_all(tag);
        OneSecPulse = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < FUSE + 1; k++) begin
            cyc(2'b00, 1'b1, tag);
            cyc(2'b00, 1'b0, tag);
        end
    endtask

    initial begin
        logic [10:0] sx0;
        resetN = 1'b0; OneSecPulse = 1'b0; drop_key = 2'b00;
        p0x = 11'd100; p0y = 11'd70; p1x = 11'd300; p1y = 11'd300;
        cyc(2'b00, 1'b0, "reset");
        cyc(2'b00, 1'b0, "reset");
        expect_val("reset_active", int'(slot_active), 0);
        resetN = 1'b1;
        cyc(2'b00, 1'b0, "idle");

        // Single drop, full fuse, slot returns to the parking position.
        cyc(2'b01, 1'b0, "r33_press");
        expect_val("r33_grant", int'(grant), 1);
        sx0 = slot_x[10:0];
        expect_val("r33_x", int'(sx0), 96);
        sx0 = slot_y[10:0];
        expect_val("r33_y", int'(sx0), 64);
        cyc(2'b00, 1'b0, "r33_rel");
        cyc(2'b00, 1'b1, "r33_p1");
        cyc(2'b00, 1'b0, "r33_w");
        cyc(2'b00, 1'b1, "r33_p2");
        expect_val("r33_noblast_early", int'(blast), 0);
        cyc(2'b00, 1'b0, "r33_w");
        cyc(2'b00, 1'b1, "r33_p3");
        expect_val("r33_blast", int'(blast), 1);
        cyc(2'b00, 1'b0, "r33_free");
        sx0 = slot_x[10:0];
        expect_val("r33_parked_x", int'(sx0), 640);
        expect_val("r33_inactive", int'(slot_active), 0);

        // Simultaneous requests, round-robin pointer.
        p0x = 11'd40; p0y = 11'd40; p1x = 11'd200; p1y = 11'd40;
        cyc(2'b11, 1'b0, "r34_both1");
        expect_val("r34_grant1", int'(grant), 3);
        expect_val("r34_owner01", int'(slot_owner[1:0]), 2);
        cyc(2'b00, 1'b0, "r34_rel");
        p0y = 11'd200; p1y = 11'd200;
        cyc(2'b11, 1'b0, "r34_both2");
        expect_val("r34_owner23", int'(slot_owner[3:2]), 1);
        drain("r34_drain");

        // Quota: third bomb for P0 is refused, P1 still allowed.
        p0x = 11'd0; p0y = 11'd0;
        cyc(2'b01, 1'b0, "r35_a"); cyc(2'b00, 1'b0, "r35_r");
        p0x = 11'd32;
        cyc(2'b01, 1'b0, "r35_b"); cyc(2'b00, 1'b0, "r35_r");
        p0x = 11'd64;
        cyc(2'b01, 1'b0, "r35_c");
        expect_val("r35_deny", int'(deny), 1);
        p1x = 11'd96; p1y = 11'd0;
        cyc(2'b00, 1'b0, "r35_r");
        cyc(2'b10, 1'b0, "r35_p1");
        expect_val("r35_p1_grant", int'(grant), 2);
        drain("r35_drain");

        // Same tile twice.
        p0x = 11'd300; p0y = 11'd300;
        cyc(2'b01, 1'b0, "r36_a"); cyc(2'b00, 1'b0, "r36_r");
        p0x = 11'd310;
        cyc(2'b01, 1'b0, "r36_b");
        expect_val("r36_deny", int'(deny), 1);
        expect_val("r36_one_active", $countones(slot_active), 1);
        drain("r36_drain");

        // Neighbouring bombs: chained or independent.
        p0x = 11'd64; p0y = 11'd64;
        cyc(2'b01, 1'b0, "r37_a"); cyc(2'b00, 1'b0, "r37_r");
        cyc(2'b00, 1'b1, "r37_p");
        p0x = 11'd128;
        cyc(2'b01, 1'b0, "r37_b"); cyc(2'b00, 1'b0, "r37_r");
        cyc(2'b00, 1'b1, "r37_p");
        cyc(2'b00, 1'b0, "r37_w");
        cyc(2'b00, 1'b1, "r37_first");
        expect_val("r37_first_blast", int'(blast), 1);
        cyc(2'b00, 1'b0, "r37_next");
        expect_val("r37_second", int'(blast), CHAIN ? 2 : 0);
        drain("r37_drain");

        // Reset mid-fuse cancels without a blast.
        p0x = 11'd200; p0y = 11'd100;
        cyc(2'b01, 1'b0, "r38_a"); cyc(2'b00, 1'b0, "r38_r");
        cyc(2'b00, 1'b1, "r38_p");
        resetN = 1'b0;
        cyc(2'b00, 1'b1, "r38_reset");
        expect_val("r38_inactive", int'(slot_active), 0);
        resetN = 1'b1;
        drain("r38_after");

        // Randomized play against the model.
        for (int n = 0; n < 800; n++) begin
            p0x = 11'($urandom_range(0, 3) * 32 + $urandom_range(0, 31));
            p0y = 11'($urandom_range(0, 1) * 32 + $urandom_range(0, 31));
            p1x = 11'($urandom_range(0, 3) * 32 + $urandom_range(0, 31));
            p1y = 11'($urandom_range(0, 1) * 32 + $urandom_range(0, 31));
            resetN = ($urandom_range(0, 199) != 0);
            cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), "rand");
        end
        resetN = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bomb_scheduler.md
BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 4: number of shared bomb slots.
REQ-002 Parameter FUSE_SEC, default 3: OneSecPulse count from arm to blast, range 1-7.
REQ-003 Parameter MAX_PER_PLAYER, default 2: maximum slots one player may hold at once.
REQ-004 Parameter BLAST_RANGE, default 2: chain reach in 32-px tiles, used only with BOMB_CHAIN_EN.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 resetN  in  1  reset, synchronous, active-low.
REQ-007 OneSecPulse  in  1  one-cycle tick, once per second.
REQ-008 drop_key  in  2  level drop key per player; bit p is player p.
REQ-009 p0_topLeftX, p0_topLeftY, p1_topLeftX, p1_topLeftY  in  11 each  player positions in pixels.
REQ-010 slot_x, slot_y  out  11*NUM_SLOTS  packed signed top-left of each slot; 640/480 when free.
REQ-011 slot_active  out  NUM_SLOTS  slot is ARMED or BLAST.
REQ-012 slot_owner  out  NUM_SLOTS  owning player per slot.
REQ-013 blast  out  NUM_SLOTS  one-cycle explosion pulse per slot.
REQ-014 grant, deny  out  2 each  one-cycle drop-request result per player.

Function
REQ-015 A request SHALL be the rising edge of drop_key[p], detected against a registered copy of drop_key.
REQ-016 A request SHALL be granted only if a FREE slot exists, the player holds fewer than MAX_PER_PLAYER slots, and no active slot is at the same snapped tile; otherwise deny[p] SHALL pulse.
REQ-017 Snapped coordinate SHALL be {pos[10:5], 5'b0} for X and Y.
REQ-018 A granted request SHALL take the lowest-index FREE slot, load its coordinates, owner and timer=FUSE_SEC, and enter ARMED; grant[p] pulses in the cycle after the request edge.
REQ-019 Simultaneous requests SHALL be arbitrated round-robin: pointer resets to player 0, the winner is granted first, and the pointer flips to the loser after each contended cycle.
REQ-020 In a contended cycle the loser SHALL be evaluated after the winner's allocation: it gets the next-lowest FREE slot, or deny if no slot, its quota is full, or its tile equals the winner's tile.
REQ-021 Slot states SHALL be FREE, ARMED, BLAST; FREE->ARMED on grant; ARMED decrements the timer on each OneSecPulse; ARMED->BLAST on OneSecPulse when timer==1; BLAST->FREE after exactly one cycle.
REQ-022 blast[i] SHALL be high exactly during slot i's BLAST cycle, i.e. after exactly FUSE_SEC OneSecPulses counted from the cycle after arming.
REQ-023 On BLAST->FREE, slot_x/slot_y SHALL return to 640/480 and the owner's held count SHALL decrement.
REQ-024 A slot freeing in cycle t SHALL be allocatable only from cycle t+1; all availability checks use registered state.
REQ-025 Per-player held counts SHALL never exceed MAX_PER_PLAYER and never underflow.

Reset
REQ-026 On resetN low at a clk edge, all slots SHALL be FREE with slot_x=640, slot_y=480, owner=0, timer=FUSE_SEC, and blast, grant, deny and counts all 0.
REQ-027 The arbitration pointer SHALL reset to player 0.
REQ-028 The registered drop_key copy SHALL reset to all ones, so a key held through reset release makes no request.
REQ-029 Reset asserted mid-fuse SHALL cancel the fuse without any blast pulse.

Configuration
REQ-030 With BOMB_CHAIN_EN defined, any ARMED slot in the same tile row or column as a slot in BLAST, within BLAST_RANGE tiles, SHALL enter BLAST in the next cycle regardless of its timer.
REQ-031 Chain-triggered slots SHALL themselves propagate chain in their BLAST cycle, one hop per cycle.
REQ-032 Without BOMB_CHAIN_EN, slots SHALL be fully independent and BLAST_RANGE SHALL be unused.

Verification
REQ-033 P0 at (100,70) presses once, FUSE_SEC=3 -> grant[0] pulses; slot0=(96,64); blast[0] is one cycle after the 3rd OneSecPulse; slot0 then returns to 640/480.
REQ-034 Both players press in the same cycle at different tiles, pointer=0 -> P0 gets slot0, P1 gets slot1; on the next contention P1 gets the lower slot.
REQ-035 P0 presses 3 times at distinct tiles with MAX_PER_PLAYER=2 -> two grants, then deny[0]; P1 can still be granted.
REQ-036 P0 presses twice on the same tile -> one grant then a deny; only one slot becomes active.
REQ-037 With BOMB_CHAIN_EN, slots at tiles (2,2) and (4,2), second armed 1 s later -> both blast, the second exactly one cycle after the first; without the macro -> 1 s apart.
REQ-038 resetN low during an ARMED countdown -> no blast; all slots report 640/480 and slot_active=0 after the reset edge.
